fifo_head_reader: RTL

- Read side of the circular entry buffer.
- The write side allocates one entry per cycle, using the one-hot write position produced by the buffer's position detector.
- This block stores the payload, keeps the per-entry valid vector, and tracks a one-hot head pointer.
- It presents the oldest entry to a valid/ready consumer and retires it in order, wrapping around the ring.

---
 rtl/fifo_head_reader_if.sv | 44 ++++
 rtl/fifo_head_reader.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fifo_head_reader_if.sv
// Bundle of the write, read and status signals of fifo_head_reader.
// slave is the view taken by the ring itself; master is the view of the
// write-side producer and read-side consumer.
// Optional macro FIFO_HEAD_READER_COUNT_EN adds the registered count output.
interface fifo_head_reader_if #(
  parameter int WIDTH  = 6,
  parameter int DATA_W = 32
) ();
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic              flush;
  logic              wr_en;
  logic [WIDTH-1:0]  wr_entry;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;
  logic [WIDTH-1:0]  valid_entry;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [WIDTH-1:0]  rd_entry;
  logic              full;
  logic              empty;
`ifdef FIFO_HEAD_READER_COUNT_EN
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, wr_en, wr_entry, wr_data, rd_ready,
    input  wr_err, valid_entry, rd_valid, rd_data, rd_entry, full, empty, count
  );
  modport slave (
    input  flush, wr_en, wr_entry, wr_data, rd_ready,
    output wr_err, valid_entry, rd_valid, rd_data, rd_entry, full, empty, count
  );
`else
  modport master (
    output flush, wr_en, wr_entry, wr_data, rd_ready,
    input  wr_err, valid_entry, rd_valid, rd_data, rd_entry, full, empty
  );
  modport slave (
    input  flush, wr_en, wr_entry, wr_data, rd_ready,
    output wr_err, valid_entry, rd_valid, rd_data, rd_entry, full, empty
  );
`endif
endinterface

// File: rtl/fifo_head_reader.sv
// Read side of the circular entry buffer: payload storage, occupancy vector
// and a one-hot head pointer that retires entries strictly in ring order.
// Writes land on a one-hot entry chosen by the write side; bad targets are
// dropped and flagged on wr_err one cycle later.
// Optional macro FIFO_HEAD_READER_COUNT_EN adds a registered occupancy count
// and a checker tying it to the occupancy vector.

`ifdef FIFO_HEAD_READER_COUNT_EN
// Checker: the running count must always equal the number of valid entries.
module fifo_head_reader_chk #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst,
  input logic [WIDTH-1:0] valid_entry,
  input logic [CNT_W-1:0] count
);
  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] ones;
    ones = {CNT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return ones;
  endfunction

  a_count_matches: assert property (@(posedge clk) disable iff (rst)
    (count == popcount(valid_entry)))
    else $error("count %0d disagrees with valid_entry %b", count, valid_entry);
endmodule
`endif

module fifo_head_reader #(
  parameter int WIDTH  = 6,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  fifo_head_reader_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] HEAD_INIT = {{(WIDTH-1){1'b0}}, 1'b1};

  // A target is usable only when exactly one bit is set.
  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    int unsigned ones;
    ones = 32'd0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + {31'd0, v[i]};
    end
    return (ones == 32'd1);
  endfunction

  logic [WIDTH-1:0]  valid_r;
  logic [WIDTH-1:0]  head_r;
  logic              wr_err_r;
  logic [DATA_W-1:0] mem_r [WIDTH];

  logic              pop_s;
  logic              wr_ok_s;
  logic              wr_drop_s;
  logic [WIDTH-1:0]  valid_nxt_s;
  logic [WIDTH-1:0]  head_nxt_s;
  logic [DATA_W-1:0] rd_data_s;

  // Next-state: pop at head and accepted write both use pre-edge occupancy,
  // so they can never hit the same entry.
  always_comb begin
    pop_s       = (|(valid_r & head_r)) & bus.rd_ready;
    wr_ok_s     = bus.wr_en & is_onehot(bus.wr_entry) & ~(|(bus.wr_entry & valid_r));
    wr_drop_s   = bus.wr_en & ~wr_ok_s;
    valid_nxt_s = valid_r;
    head_nxt_s  = head_r;
    if (pop_s) begin
      valid_nxt_s = valid_nxt_s & ~head_r;
      head_nxt_s  = {head_r[WIDTH-2:0], head_r[WIDTH-1]};
    end else begin
      valid_nxt_s = valid_nxt_s;
      head_nxt_s  = head_r;
    end
    if (wr_ok_s) begin
      valid_nxt_s = valid_nxt_s | bus.wr_entry;
    end else begin
      valid_nxt_s = valid_nxt_s;
    end
  end

  // Control state; reset and flush clear occupancy, head and the error pulse.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid_r  <= {WIDTH{1'b0}};
      head_r   <= HEAD_INIT;
      wr_err_r <= 1'b0;
    end else begin
      valid_r  <= valid_nxt_s;
      head_r   <= head_nxt_s;
      wr_err_r <= wr_drop_s;
    end
  end

  // Payload storage; contents need no reset because valid bits gate them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (wr_ok_s && !bus.flush && !rst && bus.wr_entry[i]) begin
        mem_r[i] <= bus.wr_data;
      end
    end
  end

  // Head read mux: OR of entries selected by the one-hot head.
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (head_r[i]) begin
        rd_data_s = rd_data_s | mem_r[i];
      end else begin
        rd_data_s = rd_data_s;
      end
    end
  end

  assign bus.wr_err      = wr_err_r;
  assign bus.valid_entry = valid_r;
  assign bus.rd_valid    = |(valid_r & head_r);
  assign bus.rd_data     = rd_data_s;
  assign bus.rd_entry    = head_r;
  assign bus.full        = &valid_r;
  assign bus.empty       = ~(|valid_r);

`ifdef FIFO_HEAD_READER_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] count_r;

  // Occupancy count: +1 on accepted write, -1 on pop, unchanged on both.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({wr_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.count = count_r;

  fifo_head_reader_chk #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .valid_entry (valid_r),
    .count       (count_r)
  );
`endif
endmodule
